// File: rtl/reg_ctrl_pkg.sv
// Shared types for the display-register write path: write sources, arbiter states
// and the fixed-priority pick used by the arbiter.
package reg_ctrl_pkg;

    localparam int unsigned DATA_W = 16;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_CLR  = 2'd1,
        SRC_LOAD = 2'd2,
        SRC_AUTO = 2'd3
    } src_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        HOLDOFF = 2'd2
    } arb_state_e;

    // Fixed priority CLR > LOAD > AUTO; callers mask out sources that are not eligible.
    function automatic src_e pick_src(input logic clr, input logic load, input logic aut);
        if (clr)  return SRC_CLR;
        if (load) return SRC_LOAD;
        if (aut)  return SRC_AUTO;
        return SRC_NONE;
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Brings a raw button into the clk_100 domain (2-FF synchronizer) and emits a
// one-cycle pulse on each synchronized rising edge.
module btn_sync_edge (
    input  logic clk_100,
    input  logic reset,
    input  logic btn_i,
    output logic pulse_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_100 or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign pulse_o = sync2_q & ~prev_q;

endmodule

// File: rtl/reg_write_arbiter.sv
// Write scheduler for the 16-bit display register: arbitrates clear, load and
// periodic auto writes, with a hold-off window protecting manual writes.
module reg_write_arbiter
    import reg_ctrl_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 200_000_000,
    parameter int unsigned CNT_W       = 8
) (
    input  logic              clk_100,
    input  logic              reset,
    input  logic              tick_i,
    input  logic              auto_en_i,
    input  logic              btn_clr_i,
    input  logic              btn_load_i,
    input  logic [DATA_W-1:0] sw_i,
    input  logic [DATA_W-1:0] rnd_i,
    output logic              we_o,
    output logic [DATA_W-1:0] wdata_o,
    output src_e              src_o,
    output logic              holdoff_o,
    output logic [CNT_W-1:0]  drop_cnt_o
);

    localparam int unsigned       HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    arb_state_e        state_q, state_d;
    logic              pend_clr_q, pend_clr_d;
    logic              pend_load_q, pend_load_d;
    logic              pend_auto_q, pend_auto_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0]  drop_q, drop_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    src_e              src_q, src_d;

    logic clr_pulse;
    logic load_pulse;
    logic auto_req;
    src_e grant;

    btn_sync_edge u_clr_sync (
        .clk_100 (clk_100),
        .reset   (reset),
        .btn_i   (btn_clr_i),
        .pulse_o (clr_pulse)
    );

    btn_sync_edge u_load_sync (
        .clk_100 (clk_100),
        .reset   (reset),
        .btn_i   (btn_load_i),
        .pulse_o (load_pulse)
    );

    assign auto_req = tick_i & auto_en_i;

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        pend_clr_d  = pend_clr_q;
        pend_load_d = pend_load_q;
        pend_auto_d = pend_auto_q;
        hold_d      = hold_q;
        drop_d      = drop_q;
        we_d        = 1'b0;
        wdata_d     = wdata_q;
        src_d       = src_q;
        grant       = SRC_NONE;

        unique case (state_q)
            IDLE: grant = pick_src(pend_clr_q, pend_load_q, pend_auto_q);
            WRITE: begin
                state_d = (src_q == SRC_AUTO) ? IDLE : HOLDOFF;
                hold_d  = HOLD_LOAD;
            end
            HOLDOFF: begin
                grant = pick_src(pend_clr_q, pend_load_q, 1'b0);
                if (grant == SRC_NONE) begin
                    if (hold_q == '0) state_d = IDLE;
                    else              hold_d  = hold_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (grant != SRC_NONE) begin
            state_d = WRITE;
            we_d    = 1'b1;
            src_d   = grant;
            unique case (grant)
                SRC_CLR:  wdata_d = '0;
                SRC_LOAD: wdata_d = sw_i;
                default:  wdata_d = rnd_i;
            endcase
        end

        // A grant clears only its own flag; a fresh request in the same cycle re-arms it.
        pend_clr_d  = (pend_clr_q  & (grant != SRC_CLR))  | clr_pulse;
        pend_load_d = (pend_load_q & (grant != SRC_LOAD)) | load_pulse;
        pend_auto_d =  pend_auto_q & (grant != SRC_AUTO);

        if (auto_req) begin
            if (state_q == HOLDOFF) begin
                if (drop_q != '1) drop_d = drop_q + 1'b1;
            end else begin
                pend_auto_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_100 or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            pend_clr_q  <= 1'b0;
            pend_load_q <= 1'b0;
            pend_auto_q <= 1'b0;
            hold_q      <= '0;
            drop_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            src_q       <= SRC_NONE;
        end else begin
            state_q     <= state_d;
            pend_clr_q  <= pend_clr_d;
            pend_load_q <= pend_load_d;
            pend_auto_q <= pend_auto_d;
            hold_q      <= hold_d;
            drop_q      <= drop_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            src_q       <= src_d;
        end
    end

    assign we_o       = we_q;
    assign wdata_o    = wdata_q;
    assign src_o      = src_q;
    assign holdoff_o  = (state_q == HOLDOFF);
    assign drop_cnt_o = drop_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter (HOLD_CYCLES=8, CNT_W=3): directed scenarios plus a
// randomized phase, with a reference model feeding a write scoreboard.
module tb_reg_write_arbiter;
    import reg_ctrl_pkg::*;

    localparam int HOLD = 8;
    localparam int CW   = 3;
    localparam int DROP_MAX = (1 << CW) - 1;

    logic        clk_100    = 1'b0;
    logic        reset      = 1'b1;
    logic        tick_i     = 1'b0;
    logic        auto_en_i  = 1'b0;
    logic        btn_clr_i  = 1'b0;
    logic        btn_load_i = 1'b0;
    logic [15:0] sw_i       = '0;
    logic [15:0] rnd_i      = '0;
    logic          we_o;
    logic [15:0]   wdata_o;
    src_e          src_o;
    logic          holdoff_o;
    logic [CW-1:0] drop_cnt_o;

    reg_write_arbiter #(.HOLD_CYCLES(HOLD), .CNT_W(CW)) dut (
        .clk_100    (clk_100),
        .reset      (reset),
        .tick_i     (tick_i),
        .auto_en_i  (auto_en_i),
        .btn_clr_i  (btn_clr_i),
        .btn_load_i (btn_load_i),
        .sw_i       (sw_i),
        .rnd_i      (rnd_i),
        .we_o       (we_o),
        .wdata_o    (wdata_o),
        .src_o      (src_o),
        .holdoff_o  (holdoff_o),
        .drop_cnt_o (drop_cnt_o)
    );

    always #5 clk_100 = ~clk_100;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [15:0] data;
        src_e        src;
    } wr_t;

    wr_t  exp_q[$];
    int   m_phase;          // 0 idle, 1 writing, 2 hold-off
    int   m_left;           // hold-off cycles remaining
    int   m_drop;
    bit   m_pc, m_pl, m_pa, m_manual;
    src_e m_src;
    bit [2:0] clr_hist, load_hist;   // raw button level seen at the last three edges

    task automatic model_reset();
        m_phase = 0; m_left = 0; m_drop = 0;
        m_pc = 0; m_pl = 0; m_pa = 0; m_manual = 0;
        m_src = SRC_NONE;
        clr_hist = '0; load_hist = '0;
        exp_q.delete();
    endtask

    task automatic model_step();
        src_e        g = SRC_NONE;
        logic [15:0] d;
        bit pc      = clr_hist[1]  & ~clr_hist[2];
        bit pl      = load_hist[1] & ~load_hist[2];
        bit tick_ok = tick_i && auto_en_i;
        bit in_hold = (m_phase == 2);
        case (m_phase)
            0: begin
                if (m_pc)      g = SRC_CLR;
                else if (m_pl) g = SRC_LOAD;
                else if (m_pa) g = SRC_AUTO;
            end
            1: begin
                if (m_manual) begin m_phase = 2; m_left = HOLD; end
                else m_phase = 0;
            end
            default: begin
                if (m_pc)      g = SRC_CLR;
                else if (m_pl) g = SRC_LOAD;
                else begin
                    m_left--;
                    if (m_left == 0) m_phase = 0;
                end
            end
        endcase
        if (g != SRC_NONE) begin
            d = (g == SRC_CLR) ? 16'h0000 : (g == SRC_LOAD) ? sw_i : rnd_i;
            exp_q.push_back(wr_t'{data: d, src: g});
            m_src = g; m_manual = (g != SRC_AUTO); m_phase = 1;
            if (g == SRC_CLR)  m_pc = 0;
            if (g == SRC_LOAD) m_pl = 0;
            if (g == SRC_AUTO) m_pa = 0;
        end
        if (pc) m_pc = 1;
        if (pl) m_pl = 1;
        if (tick_ok) begin
            if (in_hold) begin
                if (m_drop < DROP_MAX) m_drop++;
            end else m_pa = 1;
        end
        clr_hist  = {clr_hist[1:0], btn_clr_i};
        load_hist = {load_hist[1:0], btn_load_i};
    endtask

    always @(posedge clk_100 or posedge reset) begin
        if (reset) model_reset();
        else       model_step();
    end

    // ---------------- monitor ----------------
    wr_t mon_e;
    always @(negedge clk_100) begin
        if (!reset) begin
            check("we_cycle", we_o, m_phase == 1);
            check("holdoff_cycle", holdoff_o, m_phase == 2);
            check("drop_cnt", drop_cnt_o, m_drop);
            check("src_persist", src_o, m_src);
            if (we_o) begin
                if (exp_q.size() == 0) check("unexpected_write", exp_q.size(), 1);
                else begin
                    mon_e = exp_q.pop_front();
                    check("sb_wdata", wdata_o, mon_e.data);
                    check("sb_src", src_o, mon_e.src);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk_100);
    endtask

    task automatic pulse_tick();
        tick_i = 1'b1;
        fork
            begin @(negedge clk_100); tick_i = 1'b0; end
        join_none
    endtask

    task automatic wait_we(input int max, output int lat);
        lat = -1;
        for (int i = 1; i <= max; i++) begin
            @(negedge clk_100);
            if (we_o) begin lat = i; break; end
        end
    endtask

    task automatic wait_idle();
        int quiet = 0;
        for (int i = 0; i < 200 && quiet < 3; i++) begin
            @(negedge clk_100);
            if (!holdoff_o && !we_o) quiet++;
            else quiet = 0;
        end
        if (quiet < 3) check("idle_timeout", quiet, 3);
    endtask

    task automatic wait_hold();
        int seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            @(negedge clk_100);
            if (holdoff_o) seen = 1;
        end
        if (seen == 0) check("holdoff_timeout", seen, 1);
    endtask

    task automatic count_hold(output int n);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk_100);
            if (holdoff_o) n++;
            else if (n > 0) break;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, lat2, n;

        cyc(3);
        #1;
        check("rst_we", we_o, 1'b0);
        check("rst_wdata", wdata_o, 16'h0000);
        check("rst_src", src_o, SRC_NONE);
        check("rst_holdoff", holdoff_o, 1'b0);
        check("rst_drop", drop_cnt_o, 0);
        @(negedge clk_100);
        reset = 1'b0;
        cyc(3);

        // auto only
        auto_en_i = 1'b1; rnd_i = 16'hACE1;
        pulse_tick();
        wait_we(10, lat);
        check("auto_latency", lat, 2);
        check("auto_wdata", wdata_o, 16'hACE1);
        check("auto_src", src_o, SRC_AUTO);
        @(negedge clk_100);
        check("auto_we_single", we_o, 1'b0);
        check("auto_no_holdoff", holdoff_o, 1'b0);
        check("auto_wdata_held", wdata_o, 16'hACE1);

        // load and hold-off length
        wait_idle();
        sw_i = 16'h1234; btn_load_i = 1'b1;
        wait_we(10, lat);
        check("load_latency", lat, 4);
        check("load_wdata", wdata_o, 16'h1234);
        check("load_src", src_o, SRC_LOAD);
        btn_load_i = 1'b0;
        count_hold(n);
        check("load_holdoff_len", n, HOLD);

        // ticks during hold-off are dropped and the counter saturates
        wait_idle();
        btn_load_i = 1'b1;
        wait_hold();
        pulse_tick();
        cyc(2);
        check("drop_one", drop_cnt_o, 1);
        for (int r = 0; r < 3; r++) begin
            btn_load_i = 1'b0;
            wait_idle();
            btn_load_i = 1'b1;
            wait_hold();
            tick_i = 1'b1;
            cyc(3);
            tick_i = 1'b0;
        end
        btn_load_i = 1'b0;
        cyc(1);
        check("drop_saturate", drop_cnt_o, DROP_MAX);

        // simultaneous clear and load
        wait_idle();
        sw_i = 16'hBEEF; btn_clr_i = 1'b1; btn_load_i = 1'b1;
        wait_we(10, lat);
        check("both_clr_latency", lat, 4);
        check("both_clr_wdata", wdata_o, 16'h0000);
        check("both_clr_src", src_o, SRC_CLR);
        wait_we(10, lat2);
        check("both_load_gap", lat2, 2);
        check("both_load_wdata", wdata_o, 16'hBEEF);
        check("both_load_src", src_o, SRC_LOAD);
        count_hold(n);
        check("both_holdoff_restart", n, HOLD);
        btn_clr_i = 1'b0; btn_load_i = 1'b0;

        // reset in the middle of a write
        wait_idle();
        rnd_i = 16'h1111;
        pulse_tick();
        wait_we(10, lat);
        check("pre_reset_we", we_o, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("midrst_we", we_o, 1'b0);
        check("midrst_wdata", wdata_o, 16'h0000);
        check("midrst_src", src_o, SRC_NONE);
        check("midrst_holdoff", holdoff_o, 1'b0);
        check("midrst_drop", drop_cnt_o, 0);
        @(negedge clk_100);
        reset = 1'b0;
        cyc(2);
        rnd_i = 16'h2222;
        pulse_tick();
        wait_we(10, lat);
        check("postrst_latency", lat, 2);
        check("postrst_wdata", wdata_o, 16'h2222);
        check("postrst_src", src_o, SRC_AUTO);

        // tick alongside a manual edge, then auto disabled
        wait_idle();
        rnd_i = 16'h3333; btn_clr_i = 1'b1;
        cyc(2);
        pulse_tick();
        @(negedge clk_100);
        auto_en_i = 1'b0;
        wait_we(10, lat);
        check("mix_first_src", src_o, SRC_CLR);
        rnd_i = 16'h5A5A;
        tick_i = 1'b1;
        cyc(3);
        tick_i = 1'b0;
        wait_we(20, lat);
        check("mix_auto_src", src_o, SRC_AUTO);
        check("mix_auto_wdata", wdata_o, 16'h5A5A);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            tick_i = (i % 2 == 0);
            @(negedge clk_100);
            if (we_o) n++;
        end
        tick_i = 1'b0;
        check("disabled_no_write", n, 0);
        check("disabled_drop_same", drop_cnt_o, 0);
        btn_clr_i = 1'b0;
        auto_en_i = 1'b1;

        // randomized traffic against the model
        wait_idle();
        for (int i = 0; i < 1500; i++) begin
            tick_i    = ($urandom_range(0, 3) == 0);
            auto_en_i = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 15) == 0) btn_clr_i  = ~btn_clr_i;
            if ($urandom_range(0, 11) == 0) btn_load_i = ~btn_load_i;
            sw_i  = 16'($urandom);
            rnd_i = 16'($urandom);
            @(negedge clk_100);
        end
        tick_i = 1'b0; btn_clr_i = 1'b0; btn_load_i = 1'b0;
        cyc(40);
        check("sb_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
